// File: rtl/vga_fb_reader.sv
// vga_fb_reader: read-side scan engine for the 12-bit dual-port frame buffer.
// Generates 640x480@60 VGA timing from the 25 MHz pixel clock. Drives the buffer
// read address for a 160x120 image shown 4x upscaled. Returns RGB444 with the
// syncs delayed to line up with the buffer's one-cycle read latency.
//
// Pipeline:
//   stage 0: h/v counters and frame_start
//   stage 1: addr_out registered
//   stage 2: data_in valid, delayed flags, combinational vga_rgb
//
// The timing parameters default to standard 640x480@60.
//
// Optional build macro FB_TEST_PATTERN_EN: when it is defined and pattern_sel=1,
// active pixels show eight 80-pixel colour bars instead of buffer data.
module vga_fb_reader #(
  parameter int AW         = 15,
  parameter int DW         = 12,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  input  logic          pattern_sel,
  output logic [DW-1:0] vga_rgb,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_de,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W << SCALE_LOG2);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H << SCALE_LOG2);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0 state.
  // run is low for exactly one edge after reset. That edge parks the counters
  // at (0,0) and raises frame_start, so the scan restarts at (0,0) on the first
  // edge after reset is released.
  logic          run;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;

  // Stage 0 flags
  logic          de0, img0, hs0, vs0;
  logic [AW-1:0] addr_calc;

  // Stage 1 / stage 2 delayed flags
  logic          de_d1, img_d1, hs_d1, vs_d1;
  logic          img_d2;

  // Next counter position: wrap h at end of line, wrap v at end of frame
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (!run) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_nxt = h_cnt + HW'(1);
    end
  end

  // Stage 0 counters and frame_start, which is aligned with the counters showing (0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

  // Stage 0 region and sync decode
  // Everything is held idle while run is low, so no stray pixel can enter the pipe.
  assign de0  = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign img0 = de0 && (h_cnt < H_IMG) && (v_cnt < V_IMG);
  assign hs0  = !(run && (h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs0  = !(run && (v_cnt >= V_SS) && (v_cnt < V_SE));

  // Buffer address: (v/scale)*IMG_W + h/scale, truncated to AW bits
  assign addr_calc = AW'(v_cnt >> SCALE_LOG2) * AW'(IMG_W) + AW'(h_cnt >> SCALE_LOG2);

  // Stage 1: registered address plus first delay of the flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_out <= '0;
      de_d1    <= 1'b0;
      img_d1   <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
    end else begin
      addr_out <= img0 ? addr_calc : '0;
      de_d1    <= de0;
      img_d1   <= img0;
      hs_d1    <= hs0;
      vs_d1    <= vs0;
    end
  end

  // Stage 2: second flag delay, which lines up with data_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_de    <= 1'b0;
      img_d2    <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_de    <= de_d1;
      img_d2    <= img_d1;
      vga_hsync <= hs_d1;
      vga_vsync <= vs_d1;
    end
  end

`ifdef FB_TEST_PATTERN_EN
  // Colour-bar index, 0..7, for 80-pixel-wide bars across the active line
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar0, bar_d1, bar_d2;

  // Bar index at stage 0, from a compare ladder on h
  always_comb begin
    bar0 = '0;
    for (int i = 1; i < 8; i++)
      if (h_cnt >= HW'(i * BAR_W)) bar0 = 3'(i);
  end

  // Delay the bar index so it matches the stage 2 position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_d1 <= '0;
      bar_d2 <= '0;
    end else begin
      bar_d1 <= bar0;
      bar_d2 <= bar_d1;
    end
  end

  function automatic logic [DW-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = DW'(12'hFFF);
      3'd1:    bar_color = DW'(12'hFF0);
      3'd2:    bar_color = DW'(12'h0FF);
      3'd3:    bar_color = DW'(12'h0F0);
      3'd4:    bar_color = DW'(12'hF0F);
      3'd5:    bar_color = DW'(12'hF00);
      3'd6:    bar_color = DW'(12'h00F);
      default: bar_color = DW'(12'h000);
    endcase
  endfunction

  // Output pixel: the bars override buffer data on active pixels when selected
  always_comb begin
    vga_rgb = img_d2 ? data_in : '0;
    if (pattern_sel && vga_de) vga_rgb = bar_color(bar_d2);
  end
`else
  // This build has no test pattern. The port stays so board wiring is identical.
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;

  // Output pixel: buffer data inside the image, black elsewhere
  always_comb begin
    vga_rgb = img_d2 ? data_in : '0;
  end
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader.
// Horizontal timing is the real 800-cycle line. Vertical timing is shortened:
// 24 active lines, 2 front-porch lines, 2 sync lines and 2 back-porch lines,
// for 30 lines per frame. The image is 160x6, shown as 640x24, which keeps the
// run short. Line, hsync and vsync widths keep their real values.
// A bench cycle counter k counts posedges since reset release. Counters show
// position k-1, addr_out reflects position k-2, and vga_rgb reflects k-3.
`timescale 1ns/1ps
module tb_vga_fb_reader;

  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_in = '0;
  logic          pattern_sel = 1'b0;
  logic [DW-1:0] vga_rgb;
  logic          vga_hsync, vga_vsync, vga_de, frame_start;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  vga_fb_reader #(
    .AW(AW), .DW(DW), .IMG_W(160), .IMG_H(6), .SCALE_LOG2(2),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .addr_out(addr_out), .data_in(data_in),
    .pattern_sel(pattern_sel), .vga_rgb(vga_rgb), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_de(vga_de), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Frame buffer model with one-cycle read latency
  always @(posedge clk) data_in <= mem[addr_out];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic goto(input int target);
    if (target > k) step(target - k);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    step(3);
    release_reset();
    goto(701);  // stage 2 shows h=698, which is inside the hsync pulse
    checks++; if (vga_hsync !== 1'b0) begin errors++; $display("FAIL hsync_pre_reset: got %b want 0", vga_hsync); end
    reset = 1'b1;
    #1;
    checks++; if (addr_out !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr_out); end
    checks++; if (vga_rgb !== '0) begin errors++; $display("FAIL rst_rgb: got %h want 0", vga_rgb); end
    checks++; if (vga_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync: got %b want 1", vga_hsync); end
    checks++; if (vga_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync: got %b want 1", vga_vsync); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b want 0", vga_de); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    step(2);
    release_reset();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_at_release: got %b want 0", frame_start); end
    step(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_first_cycle: got %b want 1", frame_start); end
  endtask

  task automatic test_latency();
    step(1);  // k=2
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL de_before_first: got %b want 0", vga_de); end
    step(1);  // k=3, (0,0)
    checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL de_first: got %b want 1", vga_de); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vga_rgb !== 12'hF00) begin errors++; $display("FAIL rgb_pix%0d: got %h want f00", i, vga_rgb); end
      if (k == 6) begin
        checks++; if (addr_out !== 15'd1) begin errors++; $display("FAIL addr_4_0: got %0d want 1", addr_out); end
      end
      step(1);
    end
    // k=7, (4,0) -> addr 1
    checks++; if (vga_rgb !== 12'h0A5) begin errors++; $display("FAIL rgb_pix4: got %h want 0a5", vga_rgb); end
  endtask

  task automatic test_pattern();
    logic [DW-1:0] exp0, exp80, exp560;
`ifdef FB_TEST_PATTERN_EN
    exp0 = 12'hFFF; exp80 = 12'hFF0; exp560 = 12'h000;
`else
    exp0 = 12'hF00; exp80 = 12'h123; exp560 = 12'h456;
`endif
    pattern_sel = 1'b1;
    goto(83);   // (80,0)
    checks++; if (vga_rgb !== exp80) begin errors++; $display("FAIL pat_h80: got %h want %h", vga_rgb, exp80); end
    goto(563);  // (560,0)
    checks++; if (vga_rgb !== exp560) begin errors++; $display("FAIL pat_h560: got %h want %h", vga_rgb, exp560); end
    goto(803);  // (0,1)
    checks++; if (vga_rgb !== exp0) begin errors++; $display("FAIL pat_h0: got %h want %h", vga_rgb, exp0); end
    pattern_sel = 1'b0;
    goto(883);  // (80,1), buffer data in either build
    checks++; if (vga_rgb !== 12'h123) begin errors++; $display("FAIL pat_off_h80: got %h want 123", vga_rgb); end
  endtask

  task automatic test_mapping();
    goto(3202);  // addr for (0,4)
    checks++; if (addr_out !== 15'd160) begin errors++; $display("FAIL addr_0_4: got %0d want 160", addr_out); end
    step(1);
    checks++; if (vga_rgb !== 12'h3C7) begin errors++; $display("FAIL rgb_0_4: got %h want 3c7", vga_rgb); end
    goto(8702);  // addr for (700,10)
    checks++; if (addr_out !== 15'd0) begin errors++; $display("FAIL addr_blank: got %0d want 0", addr_out); end
    step(1);
    checks++; if (vga_rgb !== 12'h000) begin errors++; $display("FAIL rgb_blank: got %h want 000", vga_rgb); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL de_blank: got %b want 0", vga_de); end
    goto(19041);  // addr for (639,23), the last image pixel
    checks++; if (addr_out !== 15'd959) begin errors++; $display("FAIL addr_last: got %0d want 959", addr_out); end
    step(1);
    checks++; if (vga_rgb !== 12'h5A3) begin errors++; $display("FAIL rgb_last: got %h want 5a3", vga_rgb); end
    checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL de_last: got %b want 1", vga_de); end
  endtask

  task automatic test_sync();
    int hs_last = -1, hs_per = -1, hs_low = -1, hs_odd = 0;
    int vs_last = -1, vs_per = -1, vs_low = -1;
    int fs_last = -1, fs_per = -1;
    int de_cnt = 0;
    logic phs, pvs;
    phs = vga_hsync;
    pvs = vga_vsync;
    for (int t = 0; t < 30000; t++) begin
      step(1);
      if (phs && !vga_hsync) begin
        if (hs_last >= 0) begin
          if (hs_per < 0) hs_per = t - hs_last;
          else if (t - hs_last != hs_per) hs_odd++;
        end
        hs_last = t;
      end
      if (!phs && vga_hsync && hs_last >= 0 && hs_low < 0) hs_low = t - hs_last;
      if (pvs && !vga_vsync) begin
        if (vs_last >= 0 && vs_per < 0) vs_per = t - vs_last;
        vs_last = t;
      end
      if (!pvs && vga_vsync && vs_last >= 0 && vs_low < 0) vs_low = t - vs_last;
      if (frame_start) begin
        if (fs_last >= 0 && fs_per < 0) fs_per = t - fs_last;
        fs_last = t;
      end
      if (t < 24000 && vga_de) de_cnt++;
      phs = vga_hsync;
      pvs = vga_vsync;
    end
    checks++; if (hs_per != 800) begin errors++; $display("FAIL hsync_period: got %0d want 800", hs_per); end
    checks++; if (hs_odd != 0) begin errors++; $display("FAIL hsync_irregular: got %0d want 0", hs_odd); end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync_low: got %0d want 96", hs_low); end
    checks++; if (vs_per != 24000) begin errors++; $display("FAIL vsync_period: got %0d want 24000", vs_per); end
    checks++; if (vs_low != 1600) begin errors++; $display("FAIL vsync_low: got %0d want 1600", vs_low); end
    checks++; if (fs_per != 24000) begin errors++; $display("FAIL frame_period: got %0d want 24000", fs_per); end
    checks++; if (de_cnt != 15360) begin errors++; $display("FAIL de_count: got %0d want 15360", de_cnt); end
  endtask

  task automatic test_mid_reset();
    goto(64101);  // stage 2 at (97,20), addr for (99,20)
    checks++; if (addr_out !== 15'd824) begin errors++; $display("FAIL addr_99_20: got %0d want 824", addr_out); end
    checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL de_pre_midrst: got %b want 1", vga_de); end
    reset = 1'b1;
    #1;
    checks++; if (addr_out !== '0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", addr_out); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL midrst_de: got %b want 0", vga_de); end
    checks++; if (vga_rgb !== '0) begin errors++; $display("FAIL midrst_rgb: got %h want 0", vga_rgb); end
    step(2);
    release_reset();
    step(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL midrst_fs: got %b want 1", frame_start); end
    goto(2);
    checks++; if (addr_out !== 15'd0) begin errors++; $display("FAIL midrst_addr_k2: got %0d want 0", addr_out); end
    goto(6);
    checks++; if (addr_out !== 15'd1) begin errors++; $display("FAIL midrst_addr_k6: got %0d want 1", addr_out); end
    goto(10);
    checks++; if (addr_out !== 15'd2) begin errors++; $display("FAIL midrst_addr_k10: got %0d want 2", addr_out); end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 12'h777;
    mem[0]   = 12'hF00;
    mem[1]   = 12'h0A5;
    mem[20]  = 12'h123;
    mem[140] = 12'h456;
    mem[160] = 12'h3C7;
    mem[959] = 12'h5A3;
    test_reset();
    test_latency();
    test_pattern();
    test_mapping();
    test_sync();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
